// File: rtl/cellrv32_xirq_if.sv
// Purpose: host IO bus bundle for the external interrupt aggregator.
// Latency: n/a (signal bundle only).
// Backpressure: none; every decoded access is acknowledged one cycle later.
// Signals: addr (byte address), rden/wren (strobes), wdata (write data),
//          rdata (registered read data), ack (registered acknowledge).
interface cellrv32_xirq_if;
    logic [31:0] addr;
    logic        rden;
    logic        wren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output addr, rden, wren, wdata,
        input  rdata, ack
    );

    modport slave (
        input  addr, rden, wren, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/cellrv32_xirq.sv
// Purpose: collects up to 32 interrupt lines into enable-gated pending bits and raises one CPU irq for the lowest pending channel.
// Latency: rising edge sampled at k -> pending at k+1 -> ACTIVE at k+2 -> cpu_irq_o at k+3; bus ack/data one cycle after the access.
// Backpressure: none; the CPU line stays up until software writes ESC, edge pulses arriving while their pending bit is set are lost.
// Ports: clk_i/rstn_i (clock, async active-low reset), bus (slave side of the IO bus),
//        irq_i (request lines, synchronous to clk_i), cpu_irq_o (interrupt to CPU).
// Registers (addr[3:2]): 0 EIE enable, 1 EIP pending (write 0 clears), 2 ESC source/ack, 3 reserved.
module cellrv32_xirq #(
    parameter int          NUM_CH    = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFF300,
    parameter logic [31:0] TRIG_TYPE = 32'h0,
    parameter logic [31:0] TRIG_POL  = 32'hFFFFFFFF
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    cellrv32_xirq_if.slave      bus,
    input  logic [NUM_CH-1:0]   irq_i,
    output logic                cpu_irq_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [4:0]          src_q, src_d;
    logic [NUM_CH-1:0]   eie_q;
    logic [NUM_CH-1:0]   eip_q, eip_d;
    logic [NUM_CH-1:0]   irq_s, irq_d;
    logic [NUM_CH-1:0]   trig;
    logic                acc_en, rd_en, wr_en;
    logic [1:0]          sel;
    logic                esc_ack;
    logic [31:0]         rd_mux;
    logic                unused_bits;

    assign acc_en  = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign sel     = bus.addr[3:2];
    assign rd_en   = acc_en & bus.rden;
    assign wr_en   = acc_en & bus.wren;
    assign esc_ack = wr_en & (sel == 2'd2) & (state_q == ACTIVE);

    // Byte offset bits and write-data bits above NUM_CH carry no meaning here.
    assign unused_bits = &{1'b0, bus.addr[1:0], bus.wdata};

    // Trigger detection on the first sync stage; edge mode compares against the second.
    always_comb begin
        trig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (TRIG_TYPE[i])
                trig[i] = (irq_s[i] == TRIG_POL[i]) && (irq_d[i] != TRIG_POL[i]);
            else
                trig[i] = (irq_s[i] == TRIG_POL[i]);
        end
    end

    // Pending update: disable-clear beats trigger-set beats software/ack clear.
    always_comb begin
        eip_d = eip_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!eie_q[i])
                eip_d[i] = 1'b0;
            else if (trig[i])
                eip_d[i] = 1'b1;
            else if ((wr_en && (sel == 2'd1) && !bus.wdata[i]) ||
                     (esc_ack && (src_q == 5'(i))))
                eip_d[i] = 1'b0;
        end
    end

    // Arbitration FSM; src only moves on the IDLE->ACTIVE transition.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        case (state_q)
            IDLE: begin
                if (|eip_q) begin
                    for (int i = NUM_CH - 1; i >= 0; i--) begin
                        if (eip_q[i])
                            src_d = 5'(i);
                    end
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (esc_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            2'd0:    rd_mux = 32'(eie_q);
            2'd1:    rd_mux = 32'(eip_q);
            2'd2:    rd_mux = {(state_q == ACTIVE), 26'b0, src_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            src_q     <= '0;
            eie_q     <= '0;
            eip_q     <= '0;
            irq_s     <= '0;
            irq_d     <= '0;
            cpu_irq_o <= 1'b0;
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            eip_q     <= eip_d;
            irq_s     <= irq_i;
            irq_d     <= irq_s;
            cpu_irq_o <= (state_q == ACTIVE);
            bus.ack   <= acc_en & (bus.rden | bus.wren);
            bus.rdata <= rd_en ? rd_mux : 32'h0;
            if (wr_en && (sel == 2'd0))
                eie_q <= bus.wdata[NUM_CH-1:0];
        end
    end

endmodule
